// File: rtl/alu_logic_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_logic_arbiter
// Purpose  : Two-requester round-robin front end for a registered bitwise ALU;
//            one operation in flight, result held until the consumer takes it.
// Revision : 1.0 - initial release
// ============================================================================
module alu_logic_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_s,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_s,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    input  logic             res_ready,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_last;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_s;
    logic             r_id;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_id;
    logic [15:0]      r_op_count;

    logic             w_idle;
    logic             w_gnt0;
    logic             w_gnt1;
    logic [WIDTH-1:0] w_result;

    // r_last holds the most recent grant; requester 1 wins a tie only after 0 went last.
    assign w_idle     = (r_state == S_IDLE) && !rst;
    assign w_gnt1     = req1_valid && (!req0_valid || !r_last);
    assign w_gnt0     = req0_valid && !w_gnt1;
    assign req0_ready = w_idle && w_gnt0;
    assign req1_ready = w_idle && w_gnt1;

    always_comb begin
        w_result = '0;
        case (r_s)
            2'b00:   w_result = r_a & r_b;
            2'b01:   w_result = r_a | r_b;
            2'b10:   w_result = r_a ^ r_b;
            default: w_result = r_a & ~r_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= 2'b00;
            r_id        <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= 1'b0;
            r_op_count  <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req0_ready || req1_ready) begin
                        r_a     <= w_gnt1 ? req1_a : req0_a;
                        r_b     <= w_gnt1 ? req1_b : req0_b;
                        r_s     <= w_gnt1 ? req1_s : req0_s;
                        r_id    <= w_gnt1;
                        r_last  <= w_gnt1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_res_data  <= w_result;
                    r_res_id    <= r_id;
                    r_res_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_op_count  <= r_op_count + 16'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_logic_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_logic_arbiter
// Purpose  : Vector table, directed corner sequences and random traffic
//            compared against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_logic_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]   req0_s, req1_s;
    logic         req0_ready, req1_ready;
    logic         res_valid, res_id, res_ready;
    logic [W-1:0] res_data;
    logic [15:0]  op_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: is an op outstanding, how long since accept, what it must produce.
    bit           m_busy = 1'b0;
    int           m_age  = 0;
    logic [W-1:0] m_data = '0;
    bit           m_id   = 1'b0;
    int           m_last = 1;
    int unsigned  m_cnt  = 0;
    int           glog[$];

    typedef struct {
        bit           id;
        logic [1:0]   s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;
    vec_t tbl[4];

    alu_logic_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s),
        .req1_ready(req1_ready),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .res_ready(res_ready), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] alu(input logic [1:0] s, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        if (s == 2'd0)      return a & b;
        else if (s == 2'd1) return a | b;
        else if (s == 2'd2) return a ^ b;
        else                return a & ~b;
    endfunction

    // One clock cycle: entered just after a rising edge, leaves just after the next.
    task automatic step(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [1:0] s0, input bit v1, input logic [W-1:0] a1,
                        input logic [W-1:0] b1, input logic [1:0] s1, input bit rr);
        int g;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_s = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_s = s1;
        res_ready  = rr;
        #4;
        g = -1;
        if (!rst && !m_busy) begin
            if (v0 && v1)  g = 1 - m_last;
            else if (v0)   g = 0;
            else if (v1)   g = 1;
        end
        check("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
        check("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
        check("res_valid", {31'd0, res_valid}, {31'd0, m_busy && m_age >= 1});
        if (m_busy && m_age >= 1) begin
            check("res_data", {24'd0, res_data}, {24'd0, m_data});
            check("res_id", {31'd0, res_id}, {31'd0, m_id});
        end
        check("op_count", {16'd0, op_count}, m_cnt & 32'hFFFF);
        if (req0_ready) glog.push_back(0);
        if (req1_ready) glog.push_back(1);
        if (rst) begin
            m_busy = 1'b0; m_age = 0; m_last = 1; m_cnt = 0;
        end else if (!m_busy) begin
            if (g >= 0) begin
                m_busy = 1'b1; m_age = 0; m_id = (g == 1); m_last = g;
                m_data = (g == 1) ? alu(s1, a1, b1) : alu(s0, a0, b0);
            end
        end else if (m_age >= 1 && rr) begin
            m_busy = 1'b0;
            m_cnt  = (m_cnt + 1) & 32'hFFFF;
        end else begin
            m_age++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step(input bit rr);
        step(1'b0, '0, '0, 2'd0, 1'b0, '0, '0, 2'd0, rr);
    endtask

    initial begin
        tbl[0] = '{id: 1'b0, s: 2'd0, a: 8'hF0, b: 8'h3C, exp: 8'h30};
        tbl[1] = '{id: 1'b1, s: 2'd1, a: 8'hF0, b: 8'h3C, exp: 8'hFC};
        tbl[2] = '{id: 1'b1, s: 2'd2, a: 8'hF0, b: 8'h3C, exp: 8'hCC};
        tbl[3] = '{id: 1'b1, s: 2'd3, a: 8'hF0, b: 8'h3C, exp: 8'hC0};

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_s = '0; req1_a = '0; req1_b = '0; req1_s = '0;
        @(posedge clk);
        #1;
        check("reset res_data", {24'd0, res_data}, 32'd0);
        check("reset res_id", {31'd0, res_id}, 32'd0);
        step(1'b1, 8'h11, 8'h22, 2'd0, 1'b1, 8'h33, 8'h44, 2'd1, 1'b1);
        rst = 1'b0;

        // Vector table: single ops with fixed expected results and 2-cycle latency.
        foreach (tbl[i]) begin
            step(!tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].id, tbl[i].a, tbl[i].b,
                 tbl[i].s, 1'b1);
            idle_step(1'b1);
            check("tbl res_valid", {31'd0, res_valid}, 32'd1);
            check("tbl res_data", {24'd0, res_data}, {24'd0, tbl[i].exp});
            check("tbl res_id", {31'd0, res_id}, {31'd0, tbl[i].id});
            idle_step(1'b1);
        end
        check("op_count after table", {16'd0, op_count}, 32'd4);

        // Contention from reset: grants must run 0,1,0,1.
        rst = 1'b1;
        idle_step(1'b1);
        rst = 1'b0;
        glog.delete();
        for (int i = 0; i < 12; i++)
            step(1'b1, 8'(i), 8'hA5, 2'(i), 1'b1, 8'hF0, 8'(i * 7), 2'(i + 1), 1'b1);
        check("contention grants", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            check("contention order", glog[i], i % 2);
        check("contention op_count", {16'd0, op_count}, 32'd4);

        // Backpressure: five stalled HOLD cycles with both requesters pushing.
        step(1'b1, 8'h5A, 8'h0F, 2'd2, 1'b0, '0, '0, 2'd0, 1'b0);
        for (int i = 0; i < 6; i++)
            step(1'b1, 8'(i), 8'(~i), 2'd1, 1'b1, 8'(i + 9), 8'h77, 2'd3, 1'b0);
        check("bp held data", {24'd0, res_data}, {24'd0, 8'h55});
        idle_step(1'b1);
        check("bp released", {31'd0, res_valid}, 32'd0);

        // Reset while the operation is executing.
        rst = 1'b1;
        idle_step(1'b1);
        rst = 1'b0;
        step(1'b0, '0, '0, 2'd0, 1'b1, 8'hFF, 8'hFF, 2'd0, 1'b1);
        rst = 1'b1;
        idle_step(1'b1);
        rst = 1'b0;
        check("midop no result", {31'd0, res_valid}, 32'd0);
        check("midop op_count", {16'd0, op_count}, 32'd0);
        glog.delete();
        step(1'b1, 8'h01, 8'h02, 2'd1, 1'b1, 8'h03, 8'h04, 2'd1, 1'b1);
        check("midop next grant", glog.size() > 0 ? glog[0] : 9, 0);
        idle_step(1'b1);
        idle_step(1'b1);

        // Random traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            step(1'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
                 1'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
                 $urandom_range(0, 3) != 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) idle_step(1'b1);

        // Counter wrap: preload near the top, then two handshakes.
        force dut.r_op_count = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.r_op_count;
        m_cnt = 32'hFFFE;
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 8'hAA, 8'h55, 2'd1, 1'b0, '0, '0, 2'd0, 1'b1);
            idle_step(1'b1);
            idle_step(1'b1);
        end
        check("wrap op_count", {16'd0, op_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
